// File: rtl/uart_rx_simple.sv
// uart_rx_simple: 8N1 UART receiver with runtime-selectable bit divider and framing-error detection
module uart_rx_simple #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [31:0] baud_div_i,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam logic [31:0] P_DIV = 32'((CLK_FREQ + BAUD / 2) / BAUD);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t      state_q, state_d;
    logic [31:0] div_q, cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic        rx_s1_q, rx_s2_q;
    logic [31:0] half_m1;
    logic        bit_end;
    assign half_m1 = (div_q >> 1) - 32'd1;
    assign bit_end = cnt_q >= div_q - 32'd1;
    // Registers: divider reload, rx synchronizer, FSM state and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= P_DIV;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            div_q     <= baud_div_i != 32'd0 ? baud_div_i : P_DIV;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end
    // Next-state logic: mid-bit sampling with >= compares so a shrinking divider cannot strand the counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = rx_s2_q ? IDLE : START;
            end
            START: begin
                if (cnt_q >= half_m1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = bit_idx_q == 3'd7 ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    data_d  = rx_s2_q ? shift_q : data_q;
                    valid_d = rx_s2_q;
                    err_d   = !rx_s2_q;
                    state_d = rx_s2_q ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_HIGH: state_d = rx_s2_q ? IDLE : WAIT_HIGH;
            default:   state_d = IDLE;
        endcase
    end
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_simple.sv
// tb_uart_rx_simple: table-driven frame checks plus glitch, break, default-divider and mid-frame reset sequences
module tb_uart_rx_simple;
    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [31:0] baud_div_i;
    logic [7:0]  data_out;
    logic        data_valid, frame_err, busy;

    uart_rx_simple dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_div_i(baud_div_i),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0, nv = 0, ne = 0, both = 0, vcyc = 0;
    int total = 0, passed = 0;

    // Pulse monitor sampled 2 time units after each rising edge
    always @(posedge clk) begin
        cyc++;
        #2;
        if (data_valid) begin
            nv++;
            vcyc = cyc;
        end
        if (frame_err) ne++;
        if (data_valid && frame_err) both++;
    end

    typedef struct {
        int         div;
        logic [7:0] b;
        logic       stop;
        int         gap;
        int         ev;
        int         ee;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_lat(input string name, input int c0, input int div);
        int lat, e;
        lat = vcyc - c0 - 1;
        e = 2 + div / 2 + 9 * div;
        total++;
        if (lat >= e - 1 && lat <= e + 1) passed++;
        else $display("FAIL %s: latency got %0d expected %0d +/-1", name, lat, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int div, output int c0);
        rx = 1'b0;
        c0 = cyc;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(div);
        end
        rx = stop;
        tick(div);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, v0, e0;
        logic seen_busy;
        logic [7:0] held;
        vecs[0] = '{16, 8'hA5, 1'b1, 0, 1, 0, 8'hA5};
        vecs[1] = '{16, 8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[2] = '{16, 8'hFF, 1'b1, 8, 1, 0, 8'hFF};
        vecs[3] = '{16, 8'h3C, 1'b0, 8, 0, 1, 8'hFF};
        vecs[4] = '{16, 8'h55, 1'b1, 8, 1, 0, 8'h55};
        vecs[5] = '{10, 8'h81, 1'b1, 8, 1, 0, 8'h81};
        vecs[6] = '{12, 8'h7E, 1'b1, 8, 1, 0, 8'h7E};
        reset = 1'b1;
        rx = 1'b1;
        baud_div_i = 32'd16;
        tick(3);
        reset = 1'b0;
        tick(4);
        chk("reset data_out", {24'd0, data_out}, 32'h00);
        chk("reset data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);

        v0 = nv;
        e0 = ne;
        seen_busy = 1'b0;
        rx = 1'b0;
        tick(3);
        if (busy) seen_busy = 1'b1;
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (busy) seen_busy = 1'b1;
            tick(1);
        end
        chk("glitch busy seen", {31'd0, seen_busy}, 32'd1);
        chk("glitch busy dropped", {31'd0, busy}, 32'd0);
        chk("glitch no valid", nv - v0, 0);
        chk("glitch no err", ne - e0, 0);
        tick(10);

        for (int i = 0; i < 7; i++) begin
            baud_div_i = vecs[i].div;
            v0 = nv;
            e0 = ne;
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].div, c0);
            chk($sformatf("vec%0d valid count", i), nv - v0, vecs[i].ev);
            chk($sformatf("vec%0d err count", i), ne - e0, vecs[i].ee);
            chk($sformatf("vec%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].ed});
            if (vecs[i].ev != 0) chk_lat($sformatf("vec%0d", i), c0, vecs[i].div);
            rx = 1'b1;
            if (vecs[i].gap > 0) begin
                tick(vecs[i].gap);
                chk($sformatf("vec%0d busy after gap", i), {31'd0, busy}, 32'd0);
            end
        end

        baud_div_i = 32'd16;
        tick(4);
        held = data_out;
        v0 = nv;
        e0 = ne;
        send_frame(8'h3C, 1'b0, 16, c0);
        tick(1600);
        chk("break err count", ne - e0, 1);
        chk("break no valid", nv - v0, 0);
        chk("break data held", {24'd0, data_out}, 32'h7E);
        chk("break busy low line", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        tick(5);
        chk("break busy released", {31'd0, busy}, 32'd0);
        v0 = nv;
        send_frame(8'h55, 1'b1, 16, c0);
        chk("after break valid", nv - v0, 1);
        chk("after break data", {24'd0, data_out}, 32'h55);
        tick(8);

        baud_div_i = 32'd0;
        tick(4);
        v0 = nv;
        e0 = ne;
        send_frame(8'h81, 1'b1, 434, c0);
        chk("default div valid", nv - v0, 1);
        chk("default div data", {24'd0, data_out}, 32'h81);
        chk_lat("default div", c0, 434);
        tick(8);

        baud_div_i = 32'd16;
        tick(4);
        v0 = nv;
        e0 = ne;
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(16);
        end
        chk("midframe busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick(1);
        chk("midreset data_out", {24'd0, data_out}, 32'h00);
        chk("midreset data_valid", {31'd0, data_valid}, 32'd0);
        chk("midreset frame_err", {31'd0, frame_err}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        tick(1);
        reset = 1'b0;
        rx = 1'b1;
        tick(200);
        chk("midreset no valid", nv - v0, 0);
        chk("midreset no err", ne - e0, 0);
        v0 = nv;
        send_frame(8'h5A, 1'b1, 16, c0);
        chk("post reset valid", nv - v0, 1);
        chk("post reset data", {24'd0, data_out}, 32'h5A);
        tick(8);

        chk("valid and err never together", both, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
